// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, reset/bubble constants and the
// IF/ID pipeline register layout consumed by the decode stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Instructions are word aligned; the low two address bits are dropped
  // rather than trapped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: an EX redirect wins over a
// hazard stall, otherwise the PC walks sequentially (wrapping at 2^32).
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] next_pc;

  // Next-PC mux: redirect > stall > sequential
  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = word_align(redirect_target);
    end else if (stall) begin
      next_pc = pc;
    end else begin
      next_pc = pc + 32'd4;
    end
  end

  // PC register, asynchronously forced to the reset vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC onto the combinational instruction
// memory and registers the returned word into IF/ID for decode.
module fetch_stage
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  import riscv_pkg::*;

  localparam if_id_t BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0000,
    valid:    1'b0
  };

  logic [XLEN-1:0] pc_f;
  if_id_t          if_id;
  logic [31:0]     count;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall_f),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .pc             (pc_f)
  );

  assign imem_addr = pc_f;

  // IF/ID register and accepted-instruction counter. A redirect squashes
  // the wrong-path word in fetch, and any squash overrides a decode stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id <= BUBBLE;
      count <= 32'd0;
    end else if (flush_d || redirect) begin
      if_id <= BUBBLE;
    end else if (stall_d) begin
      if_id <= if_id;
    end else begin
      if_id <= '{
        instr:    imem_rdata,
        pc:       pc_f,
        pc_plus4: pc_f + 32'd4,
        valid:    1'b1
      };
      count <= count + 32'd1;
    end
  end

  assign instr_d     = if_id.instr;
  assign pc_d        = if_id.pc;
  assign pc_plus4_d  = if_id.pc_plus4;
  assign valid_d     = if_id.valid;
  assign fetch_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an instruction-level model predicts IF/ID contents
// and the PC each cycle; directed scenarios add hand-computed literal checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .fetch_count    (fetch_count)
  );

  // Instruction memory contents: two real instructions, a pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = rst ? mem_word(imem_addr) : 32'h0;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_instr, m_pc_d, m_pc4, m_cnt;
  logic        m_valid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_cnt = 32'h0;
    end else begin
      if (flush_d || redirect) begin
        m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!stall_d) begin
        m_instr = mem_word(m_pc);
        m_pc_d  = m_pc;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
      if (redirect) m_pc = redirect_target & 32'hFFFF_FFFC;
      else if (!stall_f) m_pc = m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model comparison on every falling edge
  always @(negedge clk) begin
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_instr_d", instr_d, m_instr);
    chk("m_pc_d", pc_d, m_pc_d);
    chk("m_pc_plus4_d", pc_plus4_d, m_pc4);
    chk("m_valid_d", {31'h0, valid_d}, {31'h0, m_valid});
    chk("m_fetch_count", fetch_count, m_cnt);
  end

  // The hazard unit must never request a PC hold without holding IF/ID
  always @(posedge clk) begin
    if (rst) begin
      assert (!(stall_f && !stall_d && !flush_d && !redirect))
        else $error("FAIL hazard_combo stall_f=1 stall_d=0 without flush");
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_valid", {31'h0, valid_d}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b1;

    // Reset release, first two instructions
    tick();
    chk("c1_instr", instr_d, 32'h0050_0093);
    chk("c1_pc", pc_d, 32'h0);
    chk("c1_pc4", pc_plus4_d, 32'h4);
    chk("c1_valid", {31'h0, valid_d}, 32'h1);
    tick();
    chk("c2_instr", instr_d, 32'h00A0_0113);
    chk("c2_pc", pc_d, 32'h4);
    chk("c2_count", fetch_count, 32'd2);

    // Stall both stages at pc_f=0x10
    tick(); tick();
    chk("pre_stall_addr", imem_addr, 32'h10);
    stall_f = 1'b1; stall_d = 1'b1;
    repeat (3) tick();
    chk("stall_addr", imem_addr, 32'h10);
    chk("stall_pc_d", pc_d, 32'hC);
    chk("stall_count", fetch_count, 32'd4);
    stall_f = 1'b0; stall_d = 1'b0;
    tick();
    chk("unstall_pc_d", pc_d, 32'h10);
    chk("unstall_count", fetch_count, 32'd5);
    tick();

    // Redirect overriding a stall at pc_f=0x18
    chk("pre_redir_addr", imem_addr, 32'h18);
    redirect = 1'b1; redirect_target = 32'h40; stall_f = 1'b1; stall_d = 1'b1;
    tick();
    redirect = 1'b0; stall_f = 1'b0; stall_d = 1'b0;
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_instr", instr_d, 32'h0000_0013);
    chk("redir_valid", {31'h0, valid_d}, 32'h0);
    tick();
    chk("redir_pc_d", pc_d, 32'h40);
    chk("redir_valid2", {31'h0, valid_d}, 32'h1);

    // Flush overriding stall_d, PC held then advancing per stall_f
    flush_d = 1'b1; stall_d = 1'b1; stall_f = 1'b1;
    tick();
    chk("flush_valid", {31'h0, valid_d}, 32'h0);
    chk("flush_addr", imem_addr, 32'h44);
    stall_f = 1'b0;
    tick();
    chk("flush2_addr", imem_addr, 32'h48);
    chk("flush_count", fetch_count, 32'd7);
    flush_d = 1'b0; stall_d = 1'b0;
    tick();
    chk("postflush_pc_d", pc_d, 32'h48);

    // Misaligned redirect and address wrap
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("align_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    tick();
    repeat (8) tick();
    chk("pre_areset_addr", imem_addr, 32'h24);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_addr", imem_addr, 32'h0);
    chk("areset_instr", instr_d, 32'h0000_0013);
    chk("areset_pc_d", pc_d, 32'h0);
    chk("areset_valid", {31'h0, valid_d}, 32'h0);
    chk("areset_count", fetch_count, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("restart_instr", instr_d, 32'h0050_0093);
    chk("restart_pc_d", pc_d, 32'h0);
    chk("restart_count", fetch_count, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
